// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the framed UART command sequencer.
package uart_cmd_pkg;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        TX0,
        WAIT0,
        TX1,
        WAIT1,
        RESPOND
    } state_t;

    localparam logic [7:0] CMD_WR  = 8'h01;
    localparam logic [7:0] CMD_RD  = 8'h02;
    localparam logic [7:0] RSP_ACK = 8'hAA;
    localparam logic [7:0] RSP_NAK = 8'hEE;

    // Response handed from the command FSM to the byte sequencer.
    typedef struct packed {
        logic       two;
        logic [7:0] b0;
        logic [7:0] b1;
    } resp_t;

    function automatic logic frame_chk_ok(input logic [7:0] cmd, input logic [7:0] addr,
                                          input logic [7:0] data, input logic [7:0] chk);
        return (cmd ^ addr ^ data) == chk;
    endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Sends a loaded 1- or 2-byte response over the uart_top TX handshake and
// pulses done once the last byte has fully gone out.
module uart_resp_tx
    import uart_cmd_pkg::*;
(
    input  logic       clk_50mhz,
    input  logic       reset_n,
    input  logic       load,
    input  resp_t      resp,
    input  logic       tx_active,
    input  logic       tx_done,
    output logic       tx_dv,
    output logic [7:0] tx_byte,
    output logic       done
);

    state_t state, state_nxt;
    resp_t  rsp_q;

    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            rsp_q <= '0;
        end else begin
            state <= state_nxt;
            if (load) rsp_q <= resp;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = TX0;
            TX0:     if (!tx_active) state_nxt = WAIT0;
            WAIT0:   if (tx_done) state_nxt = rsp_q.two ? TX1 : IDLE;
            TX1:     if (!tx_active) state_nxt = WAIT1;
            WAIT1:   if (tx_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tx_dv   = 1'b0;
        tx_byte = '0;
        done    = 1'b0;
        case (state)
            TX0: begin
                tx_dv   = !tx_active;
                tx_byte = rsp_q.b0;
            end
            TX1: begin
                tx_dv   = !tx_active;
                tx_byte = rsp_q.b1;
            end
            WAIT0:   done = tx_done && !rsp_q.two;
            WAIT1:   done = tx_done;
            default: ;
        endcase
    end

endmodule

// File: rtl/uart_cmd_sequencer.sv
// Framed command controller: SOF CMD ADDR DATA CHK -> register access -> ACK/NAK response.
// Optional inter-byte timeout: define UART_CMD_TIMEOUT_EN.
module uart_cmd_sequencer
    import uart_cmd_pkg::*;
#(
    parameter int         CLK_FREQ_HZ = 25_000_000,
    parameter int         TIMEOUT_US  = 1000,
    parameter logic [7:0] SOF_BYTE    = 8'h55
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_dv,
    input  logic [7:0] i_rx_byte,
    output logic       o_tx_dv,
    output logic [7:0] o_tx_byte,
    input  logic       i_tx_active,
    input  logic       i_tx_done,
    output logic       o_reg_wr,
    output logic [7:0] o_reg_addr,
    output logic [7:0] o_reg_wdata,
    input  logic [7:0] i_reg_rdata,
    output logic       o_busy,
    output logic       o_frame_err
);

    localparam int TO_CYCLES = CLK_FREQ_HZ / 1_000_000 * TIMEOUT_US;

    state_t     state, state_nxt;
    logic [7:0] cmd_q, chk_q;
    logic       in_frame, is_wr, is_rd, exec_err, rx_drop, timeout;
    logic       rsp_load, rsp_done;
    resp_t      rsp;

    assign in_frame = state inside {GET_CMD, GET_ADDR, GET_DATA, GET_CHK};
    assign is_wr    = (cmd_q == CMD_WR);
    assign is_rd    = (cmd_q == CMD_RD);
    assign exec_err = !frame_chk_ok(cmd_q, o_reg_addr, o_reg_wdata, chk_q) || !(is_wr || is_rd);
    // Bytes arriving while a frame is executing or responding are lost.
    assign rx_drop  = i_rx_dv && (state inside {EXEC, RESPOND});

`ifdef UART_CMD_TIMEOUT_EN
    localparam int             TO_W   = $clog2(TO_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TO_CYCLES);

    logic [TO_W-1:0] to_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)                 to_cnt <= '0;
        else if (!in_frame || i_rx_dv) to_cnt <= '0;
        else if (to_cnt != TO_MAX)     to_cnt <= to_cnt + 1'b1;
    end

    assign timeout = in_frame && !i_rx_dv && (to_cnt == TO_MAX);
`else
    logic unused_to_cfg;
    assign unused_to_cfg = (TO_CYCLES != 0);
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cmd_q       <= '0;
            chk_q       <= '0;
            o_reg_addr  <= '0;
            o_reg_wdata <= '0;
        end else if (i_rx_dv) begin
            case (state)
                GET_CMD:  cmd_q       <= i_rx_byte;
                GET_ADDR: o_reg_addr  <= i_rx_byte;
                GET_DATA: o_reg_wdata <= i_rx_byte;
                GET_CHK:  chk_q       <= i_rx_byte;
                default:  ;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (i_rx_dv && i_rx_byte == SOF_BYTE) state_nxt = GET_CMD;
            GET_CMD:  if (i_rx_dv) state_nxt = GET_ADDR; else if (timeout) state_nxt = IDLE;
            GET_ADDR: if (i_rx_dv) state_nxt = GET_DATA; else if (timeout) state_nxt = IDLE;
            GET_DATA: if (i_rx_dv) state_nxt = GET_CHK;  else if (timeout) state_nxt = IDLE;
            GET_CHK:  if (i_rx_dv) state_nxt = EXEC;     else if (timeout) state_nxt = IDLE;
            EXEC:     state_nxt = RESPOND;
            RESPOND:  if (rsp_done) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy      = (state != IDLE);
        o_reg_wr    = (state == EXEC) && !exec_err && is_wr;
        o_frame_err = ((state == EXEC) && exec_err) || rx_drop || timeout;
        rsp_load    = (state == EXEC);
        rsp         = '0;
        rsp.two     = !exec_err && is_rd;
        rsp.b0      = exec_err ? RSP_NAK : RSP_ACK;
        rsp.b1      = i_reg_rdata;
    end

    uart_resp_tx u_resp_tx (
        .clk_50mhz (i_clk),
        .reset_n   (i_rst_n),
        .load      (rsp_load),
        .resp      (rsp),
        .tx_active (i_tx_active),
        .tx_done   (i_tx_done),
        .tx_dv     (o_tx_dv),
        .tx_byte   (o_tx_byte),
        .done      (rsp_done)
    );

endmodule
